// File: rtl/mult_share_arb.sv
// mult_share_arb: shares one fully pipelined multiplier among NUM_REQ requesters.
// A round-robin arbiter issues at most one operand pair per cycle. An in-order
// tag FIFO sends each product back to the requester that issued it. Per-requester
// credit counters bound the number of in-flight operations. The block also drives
// the multiplier's active-low reset, so the pipeline flushes with the controller.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/a/b        per-requester operand pairs (flattened slices)
//   req_ready            combinational one-hot grant
//   rsp_valid/rsp_data   registered one-cycle product pulse to the owning requester
//   mul_rst_n            registered ~rst to the multiplier
//   mul_rdy/mul_a/mul_b  registered multiplier issue strobe and operands
//   mul_dout/mul_valid   multiplier product return
//   busy                 registered tag FIFO non-empty
//   err                  sticky: product returned with no tag outstanding
module mult_share_arb #(
  parameter int unsigned MULTLEN_1  = 8,
  parameter int unsigned MULTLEN_2  = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_OUT    = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*MULTLEN_1-1:0]     req_a,
  input  logic [NUM_REQ*MULTLEN_2-1:0]     req_b,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [MULTLEN_1+MULTLEN_2-1:0]   rsp_data,
  output logic                             mul_rst_n,
  output logic                             mul_rdy,
  output logic [MULTLEN_1-1:0]             mul_a,
  output logic [MULTLEN_2-1:0]             mul_b,
  input  logic [MULTLEN_1+MULTLEN_2-1:0]   mul_dout,
  input  logic                             mul_valid,
  output logic                             busy,
  output logic                             err
);

  localparam int unsigned PROD_W = MULTLEN_1 + MULTLEN_2;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);
  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W  = AW + 1;

  // Registered state
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q [NUM_REQ];
  logic [CNT_W-1:0]     cnt_d [NUM_REQ];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [IDX_W-1:0]     tag_mem [FIFO_DEPTH];
  logic                 mul_rdy_q, mul_rdy_d;
  logic [MULTLEN_1-1:0] mul_a_q, mul_a_d;
  logic [MULTLEN_2-1:0] mul_b_q, mul_b_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [PROD_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 mul_rst_n_q;

  // Combinational control
  logic                 fifo_full_c;
  logic                 fifo_empty_c;
  logic [NUM_REQ-1:0]   elig_c;
  logic [NUM_REQ-1:0]   grant_c;
  logic [IDX_W-1:0]     gnt_idx_c;
  logic                 gnt_any_c;
  logic                 push_c;
  logic                 pop_c;
  logic [IDX_W-1:0]     pop_tag_c;

  assign fifo_full_c  = (occ_q == OCC_W'(FIFO_DEPTH));
  assign fifo_empty_c = (occ_q == '0);
  assign pop_tag_c    = tag_mem[rd_ptr_q];

  // A requester may be granted only with a free credit and a free FIFO slot
  always_comb begin
    elig_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig_c[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT)) && !fifo_full_c && !rst;
    end
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin : arb
    logic [IDX_W-1:0] cand;
    cand      = '0;
    grant_c   = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_any_c && elig_c[cand]) begin
        gnt_any_c      = 1'b1;
        gnt_idx_c      = cand;
        grant_c[cand]  = 1'b1;
      end
    end
  end

  // A grant is always a handshake: eligibility already includes req_valid
  assign push_c = gnt_any_c;
  // A product with no outstanding tag is dropped and flagged
  assign pop_c  = mul_valid && !fifo_empty_c;

  // Next-state for issue, completion, credits and tag FIFO pointers
  always_comb begin : nxt
    logic inc;
    logic dec;
    inc         = 1'b0;
    dec         = 1'b0;
    ptr_d       = ptr_q;
    mul_rdy_d   = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q || (mul_valid && fifo_empty_c);
    wr_ptr_d    = wr_ptr_q + AW'(push_c);
    rd_ptr_d    = rd_ptr_q + AW'(pop_c);
    occ_d       = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
    busy_d      = (occ_d != '0);

    if (push_c) begin
      ptr_d     = gnt_idx_c;
      mul_rdy_d = 1'b1;
      mul_a_d   = req_a[32'(gnt_idx_c)*MULTLEN_1 +: MULTLEN_1];
      mul_b_d   = req_b[32'(gnt_idx_c)*MULTLEN_2 +: MULTLEN_2];
    end

    if (pop_c) begin
      rsp_valid_d[pop_tag_c] = 1'b1;
      rsp_data_d             = mul_dout;
    end

    // Simultaneous grant and return for one requester leave its count unchanged
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc      = push_c && (gnt_idx_c == IDX_W'(i));
      dec      = pop_c && (pop_tag_c == IDX_W'(i));
      cnt_d[i] = cnt_q[i] + CNT_W'(inc) - CNT_W'(dec);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      mul_rdy_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      mul_rst_n_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      mul_rdy_q   <= mul_rdy_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      mul_rst_n_q <= 1'b1;
    end
  end

  // Tag storage; contents are meaningless while the occupancy count is zero
  always_ff @(posedge clk) begin
    if (push_c) begin
      tag_mem[wr_ptr_q] <= gnt_idx_c;
    end
  end

  assign req_ready = grant_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mul_rst_n = mul_rst_n_q;
  assign mul_rdy   = mul_rdy_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
